key_schedule_iter: RTL and testbench
====================================

KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 Parameter: MODE_MASK, 3'b111, bitmask of enabled key lengths (bit0 = AES-128, bit1 = AES-192, bit2 = AES-256).
REQ-002 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  request to expand the key on `key`; sampled at the clock edge.
REQ-005 Port: key_len  in  2  0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = illegal.
REQ-006 Port: key  in  256  cipher key, left-justified; w0 = key[255:224], 128-bit key in key[255:128], 192-bit key in key[255:64].
REQ-007 Port: busy  out  1  expansion in progress.
REQ-008 Port: done  out  1  one-cycle pulse when expansion completes.
REQ-009 Port: err  out  1  one-cycle pulse when a start is rejected.
REQ-010 Port: num_rounds  out  4  Nr of the stored schedule (10/12/14); 0 if none stored.
REQ-011 Port: rk_rd  in  1  round-key read strobe.
REQ-012 Port: rk_idx  in  4  round index for the read.
REQ-013 Port: rk_out  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered.
REQ-014 Port: rk_valid  out  1  rk_out valid; registered.

Function
REQ-015 The block SHALL hold a 60 x 32-bit word store plus registers for state, word counter, Rcon and Nk.
REQ-016 The state machine SHALL have states IDLE and EXPAND; IDLE->EXPAND on an accepted start; EXPAND->IDLE on the edge that writes the last word.
REQ-017 A start SHALL be accepted only in IDLE and only if key_len != 3 and MODE_MASK[key_len] = 1.
REQ-018 A start in IDLE with an illegal or disabled key_len SHALL pulse err for one cycle and SHALL leave the store, num_rounds and the valid schedule unchanged.
REQ-019 A start while busy SHALL be ignored: no err, no restart.
REQ-020 On the accepting edge the block SHALL:
- write w[0..Nk-1] from key;
- set busy = 1;
- clear the valid-schedule flag;
- set Rcon = 8'h01;
- set i = Nk (Nk = 4, 6 or 8).
REQ-021 In EXPAND the block SHALL write exactly one word w[i] per cycle, in ascending i, using temp = w[i-1] and:
- if i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon <= xtime(Rcon) (so 01, 02, ... 80, 1b, 36);
- else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp);
- w[i] = w[i-Nk] ^ temp.
REQ-022 RotWord SHALL rotate bytes left ({b1, b2, b3, b0}); SubWord SHALL apply the codebase AES sbox to each byte (4 instances).
REQ-023 The last word index SHALL be 43, 51 or 59; busy SHALL stay high for exactly 40, 46 or 52 cycles.
REQ-024 On the edge writing the last word the block SHALL:
- clear busy;
- pulse done for one cycle;
- set num_rounds = 10/12/14;
- set the valid-schedule flag.
REQ-025 Read port: when rk_rd is sampled high, on the next edge rk_out SHALL show round key rk_idx and rk_valid SHALL be 1, but only if the schedule is valid, busy = 0 and rk_idx <= num_rounds.
REQ-026 If the REQ-025 conditions do not hold, the read SHALL set rk_out = 0 and rk_valid = 0; with rk_rd = 0, rk_valid SHALL be 0 and rk_out SHALL hold its value.
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 While rst = 1, outputs SHALL be: busy = 0, done = 0, err = 0, rk_valid = 0, rk_out = 0, num_rounds = 0; state SHALL be IDLE and the valid-schedule flag SHALL be cleared.
REQ-029 Reset SHALL be asynchronous and SHALL take effect immediately.
REQ-030 Reset mid-expansion SHALL abort the expansion; store contents are don't-care and are never readable as valid until a new expansion completes.

Verification
REQ-031 key_len = 0, key = 2b7e1516_28aed2a6_abf71588_09cf4f3c -> done after 40 busy cycles, num_rounds = 10; rk_idx = 10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rk_idx = 0 -> the key.
REQ-032 key_len = 1, key = 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> 46 busy cycles, num_rounds = 12; rk_idx = 12 -> e98ba06f_448c773c_8ecc7204_01002202.
REQ-033 key_len = 2, key = 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> 52 busy cycles, num_rounds = 14; rk_idx = 14 -> fe4890d1_e6188d0b_046df344_706c631e.
REQ-034 key_len = 3, or MODE_MASK = 3'b001 with key_len = 2 -> single err pulse, busy stays 0, prior schedule still readable with rk_valid = 1.
REQ-035 Second start 5 cycles into an expansion -> ignored, done after the original cycle count; rk_rd during busy -> rk_valid = 0; rk_idx = 11 after AES-128 -> rk_valid = 0, rk_out = 0.
REQ-036 rst pulsed at cycle 20 of an expansion -> busy = 0 and num_rounds = 0 immediately, no done pulse; a subsequent read returns rk_valid = 0.

Source files
------------

// File: rtl/key_schedule_iter.sv
// Iterative AES key expansion: one 32-bit schedule word per clock into a 60-word store,
// with a registered round-key read port.
module key_schedule_iter #(
  parameter logic [2:0] MODE_MASK = 3'b111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   num_rounds,
  input  logic         rk_rd,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid
);

  localparam int unsigned WORDS = 60;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state;
  logic [31:0] w [WORDS];
  logic [5:0]  idx;         // index of the word written this cycle
  logic [2:0]  phase;       // idx mod nk, tracked incrementally
  logic [3:0]  nk;
  logic [7:0]  rcon;
  logic        sched_valid;

  logic [3:0]  mask_ext;
  logic [3:0]  nk_in;
  logic        accept_c;
  logic [5:0]  last_idx;
  logic [31:0] temp, sub_in, sub_out, mixed, new_word;
  logic [5:0]  rd_base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign mask_ext = {1'b0, MODE_MASK};
  assign nk_in    = (key_len == 2'd0) ? 4'd4 : (key_len == 2'd1) ? 4'd6 : 4'd8;
  assign accept_c = start && (state == IDLE) && mask_ext[key_len];
  assign rd_base  = {rk_idx, 2'b00};

  // Next schedule word from w[idx-1] and w[idx-nk]
  always_comb begin
    last_idx = 6'd59;
    case (nk)
      4'd4:    last_idx = 6'd43;
      4'd6:    last_idx = 6'd51;
      default: last_idx = 6'd59;
    endcase
    temp    = w[idx - 6'd1];
    sub_in  = (phase == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
    mixed   = temp;
    if (phase == 3'd0)
      mixed = sub_out ^ {rcon, 24'h000000};
    else if ((nk == 4'd8) && (phase == 3'd4))
      mixed = sub_out;
    new_word = w[idx - 6'(nk)] ^ mixed;
  end

  // Word store: key load on acceptance, one derived word per expansion cycle
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nk_in) w[k] <= key[255 - 32*k -: 32];
      end
    end else if (state == EXPAND) begin
      w[idx] <= new_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      num_rounds  <= 4'd0;
      rk_out      <= 128'd0;
      rk_valid    <= 1'b0;
      sched_valid <= 1'b0;
      idx         <= 6'd0;
      phase       <= 3'd0;
      nk          <= 4'd0;
      rcon        <= 8'd0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            state       <= EXPAND;
            busy        <= 1'b1;
            sched_valid <= 1'b0;
            num_rounds  <= 4'd0;
            rcon        <= 8'h01;
            nk          <= nk_in;
            idx         <= 6'(nk_in);
            phase       <= 3'd0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        EXPAND: begin
          idx   <= idx + 6'd1;
          phase <= (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= xtime(rcon);
          if (idx == last_idx) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            num_rounds  <= nk + 4'd6;
            sched_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Round-key read; a rejected read clears rk_out
      if (rk_rd) begin
        if (sched_valid && !busy && (rk_idx <= num_rounds)) begin
          rk_out   <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
          rk_valid <= 1'b1;
        end else begin
          rk_out <= 128'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_iter.sv
// Randomized and known-answer bench for key_schedule_iter against a FIPS-197 style
// key expansion model whose S-box is derived from GF(2^8) inversion.
module tb_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, start2 = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         rk_rd = 1'b0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done, err, rk_valid;
  logic [3:0]   num_rounds;
  logic [127:0] rk_out;
  logic         busy2, done2, err2, rk_valid2;
  logic [3:0]   num_rounds2;
  logic [127:0] rk_out2;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  key_schedule_iter dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err), .num_rounds(num_rounds),
    .rk_rd(rk_rd), .rk_idx(rk_idx), .rk_out(rk_out), .rk_valid(rk_valid)
  );

  key_schedule_iter #(.MODE_MASK(3'b001)) dut128 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len), .key(key),
    .busy(busy2), .done(done2), .err(err2), .num_rounds(num_rounds2),
    .rk_rd(rk_rd), .rk_idx(rk_idx), .rk_out(rk_out2), .rk_valid(rk_valid2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse (x^254)
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h01;
      if (v == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic rd(input logic [3:0] i, output logic [127:0] o, output logic v);
    @(negedge clk); rk_idx = i; rk_rd = 1'b1;
    @(negedge clk); rk_rd = 1'b0; o = rk_out; v = rk_valid;
  endtask

  // Start an expansion on dut and follow it to completion
  task automatic run_expand(input logic [1:0] kl, input logic [255:0] k, input bit probe);
    int cnt = 0;
    bit bad = 1'b0;
    int exp_cyc = (kl == 2'd0) ? 40 : (kl == 2'd1) ? 46 : 52;
    int exp_nr  = (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
    @(negedge clk); start = 1'b1; key_len = kl; key = k;
    @(negedge clk); start = 1'b0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (err || done) bad = 1'b1;
      if (probe && cnt == 11) chk("rd_during_busy", 128'(rk_valid), 128'd0);
      start = probe && (cnt == 5);
      rk_rd = probe && (cnt == 10);
      @(negedge clk);
    end
    start = 1'b0; rk_rd = 1'b0;
    chk("busy_cycles", 128'(cnt), 128'(exp_cyc));
    chk("done_pulse", 128'(done), 128'd1);
    chk("no_err_no_early_done", 128'(bad), 128'd0);
    chk("num_rounds", 128'(num_rounds), 128'(exp_nr));
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] o;
    logic         v;
    logic [255:0] rk;
    int           cnt, kl, nk, nr;
    bit           bad;

    build_sbox();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("rst_rk_out", rk_out, 128'd0);
    chk("rst_num_rounds", 128'(num_rounds), 128'd0);
    rst = 1'b0;
    rd(4'd0, o, v);
    chk("rd_before_any_sched", 128'(v), 128'd0);

    // AES-128 known answer, with a mid-expansion start and a busy read
    rk = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    run_expand(2'd0, rk, 1'b1);
    rd(4'd10, o, v);
    chk("kat128_rk10", o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("kat128_rk10_valid", 128'(v), 128'd1);
    rd(4'd0, o, v);
    chk("kat128_rk0", o, rk[255:128]);
    @(negedge clk);
    chk("hold_rk_valid", 128'(rk_valid), 128'd0);
    chk("hold_rk_out", rk_out, rk[255:128]);
    rd(4'd11, o, v);
    chk("rd_idx11_valid", 128'(v), 128'd0);
    chk("rd_idx11_out", o, 128'd0);

    // Illegal key length
    @(negedge clk); start = 1'b1; key_len = 2'd3;
    @(negedge clk); start = 1'b0;
    chk("illegal_err", 128'(err), 128'd1);
    chk("illegal_busy", 128'(busy), 128'd0);
    @(negedge clk);
    chk("illegal_err_one_cycle", 128'(err), 128'd0);
    chk("illegal_num_rounds", 128'(num_rounds), 128'd10);
    rd(4'd10, o, v);
    chk("illegal_keeps_sched", o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("illegal_keeps_valid", 128'(v), 128'd1);

    // AES-192 and AES-256 known answers
    run_expand(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b0);
    rd(4'd12, o, v);
    chk("kat192_rk12", o, 128'he98ba06f448c773c8ecc720401002202);
    chk("kat192_valid", 128'(v), 128'd1);
    run_expand(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0);
    rd(4'd14, o, v);
    chk("kat256_rk14", o, 128'hfe4890d1e6188d0b046df344706c631e);
    chk("kat256_valid", 128'(v), 128'd1);

    // Instance with only AES-128 enabled: load a schedule, then request AES-256
    @(negedge clk); start2 = 1'b1; key_len = 2'd0; key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    @(negedge clk); start2 = 1'b0;
    cnt = 0;
    while (busy2 === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    chk("mask_busy_cycles", 128'(cnt), 128'd40);
    @(negedge clk); start2 = 1'b1; key_len = 2'd2;
    @(negedge clk); start2 = 1'b0;
    chk("mask_err", 128'(err2), 128'd1);
    chk("mask_busy", 128'(busy2), 128'd0);
    @(negedge clk);
    chk("mask_err_one_cycle", 128'(err2), 128'd0);
    chk("mask_num_rounds", 128'(num_rounds2), 128'd10);
    rd(4'd10, o, v);
    chk("mask_keeps_sched", rk_out2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("mask_keeps_valid", 128'(rk_valid2), 128'd1);

    // Random keys against the model, every round key plus one past the end
    for (int it = 0; it < 6; it++) begin
      kl = (it < 3) ? it : int'($urandom_range(0, 2));
      nk = 4 + 2 * kl;
      nr = nk + 6;
      for (int q = 0; q < 8; q++) rk[255 - 32*q -: 32] = $urandom;
      model_expand(nk, rk);
      run_expand(2'(kl), rk, 1'b0);
      for (int r = 0; r <= nr; r++) begin
        rd(4'(r), o, v);
        chk($sformatf("rand%0d_nk%0d_rk%0d", it, nk, r), o, {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        chk($sformatf("rand%0d_rk%0d_valid", it, r), 128'(v), 128'd1);
      end
      rd(4'(nr + 1), o, v);
      chk($sformatf("rand%0d_past_end", it), {127'd0, v} | o, 128'd0);
    end

    // Reset in the middle of an expansion
    @(negedge clk); start = 1'b1; key_len = 2'd2; key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_reset_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 128'(busy), 128'd0);
    chk("async_rst_num_rounds", 128'(num_rounds), 128'd0);
    @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done || busy) bad = 1'b1;
      @(negedge clk);
    end
    chk("no_done_after_abort", 128'(bad), 128'd0);
    rd(4'd0, o, v);
    chk("rd_after_abort_valid", 128'(v), 128'd0);
    chk("rd_after_abort_out", o, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
